uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side frame controller for the UART link.
- Sequences the receive baud tick generator by gating its clock-enable input, and samples the synchronised serial line on each mid-bit tick.
- Assembles 8N1-style frames (width set by DATA_BITS) and presents each byte through a one-entry valid/ready output buffer to the matrix loader.
- Reports stop-bit framing errors and overruns as one-cycle pulses.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first; legal range 5..9.
- SYNC_STAGES, 2: flops in the rx input synchroniser; minimum 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- rx  in  1  asynchronous serial input; idle high
- baud_tick  in  1  one-cycle pulse from the tick generator at mid-bit
- baud_ena  out  1  clock-enable to the tick generator
- data  out  DATA_BITS  received word
- data_valid  out  1  data holds an unconsumed word
- data_ready  in  1  consumer accepts the word
- frame_err  out  1  one-cycle pulse: bad stop bit
- overrun  out  1  one-cycle pulse: good frame dropped because the buffer was full

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk.
  - All synchroniser flops reset to 1.
  - State resets to IDLE.
  - All outputs reset to 0: baud_ena, data_valid, data, frame_err, overrun.
  - The bit counter and shift register reset to 0.
  - Reset mid-frame aborts the frame and produces no pulse.
- Tick source contract: while baud_ena=0 the tick generator holds its counter. After baud_ena rises, the first baud_tick arrives about half a bit period later, then one tick every bit period. baud_tick is ignored in IDLE.
- rx_s is the output of the last synchroniser stage; the controller uses only rx_s.
- State machine:
  - IDLE: baud_ena=0.
    - rx_s=0 → START; baud_ena=1 from the next cycle.
  - START: baud_ena=1.
    - On tick with rx_s=0 → DATA; bit counter cleared.
    - On tick with rx_s=1 (glitch, false start) → IDLE; no pulses.
  - DATA: on each tick, shift right with rx_s entering the MSB, so the LSB is received first; bit counter +1.
    - On the tick that samples bit DATA_BITS-1 → STOP.
  - STOP: on tick → IDLE; baud_ena drops the following cycle.
    - rx_s=1: frame good, go to delivery.
    - rx_s=0: frame_err=1 for one cycle; data is not delivered; the buffer is unchanged.
- IDLE always lasts at least one cycle with baud_ena=0 between frames, which resets the tick phase.
- Delivery (good stop), evaluated in the cycle of the STOP tick:
  - Buffer empty, or data_valid & data_ready in that same cycle: data loads the shift register and data_valid=1 on the next cycle. Latency is 1 clk after the STOP tick.
  - Buffer full with no accept in that cycle: the new word is dropped, data/data_valid are held, and overrun=1 for one cycle.
- Output handshake:
  - Transfer occurs when data_valid & data_ready.
  - After a transfer, data_valid=0 on the next cycle unless a new word loads in that cycle, in which case it stays 1.
  - data is stable while data_valid=1 and not accepted.
  - data_ready while data_valid=0 has no effect.
- frame_err and overrun are never asserted together and never for more than one cycle.
- A break condition (rx held low) produces a frame_err per frame time, then restarts from IDLE whenever rx_s is 0.

Test Plan:
- Bench setup: tick generator instantiated with divisor 16; data_ready=1 unless stated otherwise.
- Single frame 0xA5, good stop → data=0xA5 with data_valid high 1 cycle after the STOP tick; no error pulses; baud_ena returns to 0.
- Back-to-back frames 0x00, 0xFF, 0x3C with 1 stop bit each → three transfers in order; baud_ena low for at least 1 cycle between frames.
- Start-bit glitch (rx low 4 clks) → START exits to IDLE at the first tick; no data_valid, frame_err or overrun.
- Frame 0x81 with stop bit 0 → frame_err pulses once 1 cycle after the STOP tick; data_valid remains 0.
- data_ready=0; frames 0x11 then 0x22 → data=0x11 held, overrun pulses once at the second frame; raising data_ready delivers only 0x11.
- Two edge cases:
  - data_ready asserted in exactly the STOP-tick cycle of a second frame → 0x11 transfers, 0x22 loads, data_valid stays 1, no overrun.
  - rstn low during bit 3 → next cycle all outputs 0 and state IDLE; the following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Output side of the UART receive controller: received word with valid/ready
// handshake, plus the one-cycle error pulses that accompany it.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data, data_valid, frame_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, frame_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: gates the baud tick generator, samples the
// synchronised line at mid-bit and hands each good word to a one-entry buffer.
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rx_i,
  input  logic           baud_tick_i,
  output logic           baud_ena_o,
  uart_rx_ctrl_if.master out_if
);

  localparam int                CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_ctrl: DATA_BITS must be in 5..9");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("uart_rx_ctrl: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic rx_s;
  logic stop_good;
  logic stop_bad;
  logic accept;
  logic load;

  // NOTE: the synchroniser resets to the idle-high line level so leaving reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // NOTE: every register is written with <= so all flops update from the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: each output of this block gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (baud_tick_i) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_tick_i) begin
          // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick_i) begin
          state_d   = IDLE;
          stop_good = rx_s;
          stop_bad  = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An accept in the STOP-tick cycle frees the buffer for the new word.
  always_comb begin
    accept      = valid_q && out_if.data_ready;
    load        = stop_good && (!valid_q || accept);
    data_d      = load ? shift_q : data_q;
    valid_d     = load ? 1'b1 : (accept ? 1'b0 : valid_q);
    frame_err_d = stop_bad;
    overrun_d   = stop_good && valid_q && !accept;
  end

  assign baud_ena_o        = (state_q != IDLE);
  assign out_if.data       = data_q;
  assign out_if.data_valid = valid_q;
  assign out_if.frame_err  = frame_err_q;
  assign out_if.overrun    = overrun_q;

  a_pulses_exclusive : assert property (
    @(posedge clk) disable iff (!rstn) !(frame_err_q && overrun_q)
  );

  a_data_held : assert property (
    @(posedge clk) disable iff (!rstn)
      (valid_q && !out_if.data_ready) |=> (valid_q && $stable(data_q))
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a divide-by-16 tick generator model and
// a negedge monitor that logs transfers and error pulses.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS = 8;
  localparam int BIT_CLKS  = 16;
  localparam int STOP_IDX  = DATA_BITS + 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rx   = 1'b1;
  logic baud_tick;
  logic baud_ena;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  uart_rx_ctrl #(
    .DATA_BITS  (DATA_BITS),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_i       (rx),
    .baud_tick_i(baud_tick),
    .baud_ena_o (baud_ena),
    .out_if     (rx_if)
  );

  // Tick generator: holds while disabled, first tick half a bit after enable.
  logic [3:0] div_q  = '0;
  logic       tick_q = 1'b0;
  int         tick_n = 0;

  always @(posedge clk) begin
    if (!baud_ena) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      tick_n <= 0;
    end else begin
      div_q  <= div_q + 4'd1;
      tick_q <= (div_q == 4'd7);
      if (div_q == 4'd7) tick_n <= tick_n + 1;
    end
  end

  assign baud_tick = tick_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor
  int                   cyc = 0;
  logic [DATA_BITS-1:0] got_q[$];
  logic [DATA_BITS-1:0] exp_q[$];
  int fe_cnt, ov_cnt, both_cnt, ena_rises;
  int stop_cyc, valid_rise_cyc, fe_cyc, ov_cyc;
  logic prev_ena   = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (baud_tick && tick_n == STOP_IDX) stop_cyc = cyc;
    if (rx_if.data_valid && !prev_valid) valid_rise_cyc = cyc;
    if (baud_ena && !prev_ena) ena_rises++;
    if (rx_if.frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (rx_if.overrun) begin ov_cnt++; ov_cyc = cyc; end
    if (rx_if.frame_err && rx_if.overrun) both_cnt++;
    if (rx_if.data_valid && rx_if.data_ready) got_q.push_back(rx_if.data);
    prev_valid = rx_if.data_valid;
    prev_ena   = baud_ena;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_cnt         = 0;
    ov_cnt         = 0;
    both_cnt       = 0;
    ena_rises      = 0;
    stop_cyc       = -100;
    valid_rise_cyc = -200;
    fe_cyc         = -300;
    ov_cyc         = -400;
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    clear_mon();
    rx_if.data_ready = 1'b1;
    rstn = 1'b0;
    step(4);
    check("rst_baud_ena", 32'(baud_ena), 0);
    check("rst_valid", 32'(rx_if.data_valid), 0);
    check("rst_data", 32'(rx_if.data), 0);
    check("rst_frame_err", 32'(rx_if.frame_err), 0);
    check("rst_overrun", 32'(rx_if.overrun), 0);
    rstn = 1'b1;
    step(4);

    // Single good frame
    clear_mon();
    send_frame(8'hA5, 1'b1);
    step(8);
    exp_q = '{8'hA5};
    check_words("a5");
    check("a5_latency", 32'(valid_rise_cyc - stop_cyc), 1);
    check("a5_frame_err", 32'(fe_cnt), 0);
    check("a5_overrun", 32'(ov_cnt), 0);
    check("a5_baud_ena_idle", 32'(baud_ena), 0);

    // Back-to-back frames
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    step(8);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    check_words("b2b");
    check("b2b_ena_rises", 32'(ena_rises), 3);
    check("b2b_errors", 32'(fe_cnt + ov_cnt), 0);

    // Start-bit glitch
    clear_mon();
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    exp_q = '{};
    check_words("glitch");
    check("glitch_entered_start", 32'(ena_rises), 1);
    check("glitch_baud_ena", 32'(baud_ena), 0);
    check("glitch_valid", 32'(rx_if.data_valid), 0);
    check("glitch_errors", 32'(fe_cnt + ov_cnt), 0);

    // Bad stop bit
    clear_mon();
    send_frame(8'h81, 1'b0);
    step(40);
    exp_q = '{};
    check_words("badstop");
    check("badstop_fe_count", 32'(fe_cnt), 1);
    check("badstop_fe_latency", 32'(fe_cyc - stop_cyc), 1);
    check("badstop_valid", 32'(rx_if.data_valid), 0);
    check("badstop_overrun", 32'(ov_cnt), 0);

    // Overrun with consumer stalled
    clear_mon();
    rx_if.data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(8);
    check("ovr_valid", 32'(rx_if.data_valid), 1);
    check("ovr_data_held", 32'(rx_if.data), 32'h11);
    check("ovr_count", 32'(ov_cnt), 1);
    check("ovr_latency", 32'(ov_cyc - stop_cyc), 1);
    check("ovr_frame_err", 32'(fe_cnt), 0);
    rx_if.data_ready = 1'b1;
    step(4);
    exp_q = '{8'h11};
    check_words("ovr");
    check("ovr_drained_valid", 32'(rx_if.data_valid), 0);

    // Accept in exactly the STOP-tick cycle of the second frame
    clear_mon();
    rx_if.data_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    step(8);
    check("edge_first_data", 32'(rx_if.data), 32'h11);
    found = 1'b0;
    fork
      send_frame(8'h22, 1'b1);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          step(1);
          if (baud_tick && tick_n == STOP_IDX) begin
            rx_if.data_ready = 1'b1;
            step(1);
            rx_if.data_ready = 1'b0;
            found = 1'b1;
            check("edge_valid_kept", 32'(rx_if.data_valid), 1);
            check("edge_new_data", 32'(rx_if.data), 32'h22);
          end
        end
      end
    join
    check("edge_stop_tick_seen", 32'(found), 1);
    step(8);
    exp_q = '{8'h11};
    check_words("edge_accept");
    check("edge_overrun", 32'(ov_cnt), 0);
    rx_if.data_ready = 1'b1;
    step(4);
    exp_q = '{8'h11, 8'h22};
    check_words("edge_drain");

    // Reset during data bit 3, with a word parked in the buffer
    clear_mon();
    rx_if.data_ready = 1'b0;
    send_frame(8'h33, 1'b1);
    step(8);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    step(8);
    rstn = 1'b0;
    step(1);
    check("midrst_baud_ena", 32'(baud_ena), 0);
    check("midrst_valid", 32'(rx_if.data_valid), 0);
    check("midrst_data", 32'(rx_if.data), 0);
    check("midrst_frame_err", 32'(rx_if.frame_err), 0);
    check("midrst_overrun", 32'(rx_if.overrun), 0);
    rx   = 1'b1;
    rstn = 1'b1;
    step(40);
    check("midrst_no_pulses", 32'(fe_cnt + ov_cnt), 0);
    check("midrst_idle", 32'(baud_ena), 0);
    clear_mon();
    rx_if.data_ready = 1'b1;
    send_frame(8'h5A, 1'b1);
    step(8);
    exp_q = '{8'h5A};
    check_words("postrst");
    check("postrst_errors", 32'(fe_cnt + ov_cnt), 0);
    check("never_both_pulses", 32'(both_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
